// File: rtl/memory_stage.sv
// Memory stage of the in-order pipeline. It waits for the data-memory response
// of a load/store, extracts load data (including LWL/LWR merges with rt), and
// registers the writeback payload whenever the writeback stage is ready.
// It also forwards the current result to decode.
`ifndef I_MAX
`define I_MAX 8
`endif
`ifndef I_MEM_R
`define I_MEM_R 0
`endif
`ifndef I_MEM_W
`define I_MEM_W 1
`endif
`ifndef I_WEX
`define I_WEX 2
`endif

module memory_stage (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  input  logic [`I_MAX-1:0] ctrl_i,
  input  logic [31:0]       result_i,
  input  logic [31:0]       eaddr_i,
  input  logic [31:0]       rdata2_i,
  input  logic [4:0]        waddr_i,
  output logic              done_o,
  input  logic [31:0]       data_rdata,
  input  logic              data_data_ok,
  input  logic              ready_i,
  output logic [4:0]        fwd_addr,
  output logic [31:0]       fwd_data,
  output logic              fwd_ok,
  output logic              valid_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic [4:0]        waddr_o,
  output logic [31:0]       wdata_o,
  output logic              wen_o
);

  // Primary opcodes of the load instructions; load width is taken from inst_i.
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HELD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;
  logic        valid_q, wen_q;
  logic [31:0] pc_q, inst_q, wdata_q;
  logic [4:0]  waddr_q;

  logic        mem_op;
  logic        is_load;
  logic        done;
  logic [31:0] load_word;
  logic [31:0] wdata;

  // Select the loaded bytes by opcode and address offset; unaligned LWL/LWR
  // merge the loaded word with the old rt value.
  function automatic logic [31:0] load_extract(input logic [5:0]  op,
                                               input logic [1:0]  off,
                                               input logic [31:0] m,
                                               input logic [31:0] rt);
    logic [31:0]        shifted;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sx;
    logic [31:0]        r;
    shifted = m >> {off, 3'b000};
    sb      = signed'(shifted[7:0]);
    sh      = signed'(off[1] ? m[31:16] : m[15:0]);
    sx      = '0;
    r       = m;
    case (op)
      OP_LB: begin
        sx = sb;
        r  = sx;
      end
      OP_LBU: r = {24'd0, shifted[7:0]};
      OP_LH: begin
        sx = sh;
        r  = sx;
      end
      OP_LHU: r = {16'd0, (off[1] ? m[31:16] : m[15:0])};
      OP_LWL: begin
        case (off)
          2'd0:    r = {m[7:0],  rt[23:0]};
          2'd1:    r = {m[15:0], rt[15:0]};
          2'd2:    r = {m[23:0], rt[7:0]};
          default: r = m;
        endcase
      end
      OP_LWR: begin
        case (off)
          2'd0:    r = m;
          2'd1:    r = {rt[31:24], m[31:8]};
          2'd2:    r = {rt[31:16], m[31:16]};
          default: r = {rt[31:8],  m[31:24]};
        endcase
      end
      OP_LW:   r = m;
      default: r = m;
    endcase
    return r;
  endfunction

  // Completion, load data selection, forwarding and next-state decode.
  always_comb begin
    mem_op    = ctrl_i[`I_MEM_R] | ctrl_i[`I_MEM_W];
    is_load   = ctrl_i[`I_MEM_R];
    done      = valid_i && (!mem_op || data_data_ok || (state_q == S_HELD));
    load_word = (state_q == S_HELD) ? rdata_hold_q : data_rdata;
    wdata     = is_load ? load_extract(inst_i[31:26], eaddr_i[1:0], load_word, rdata2_i)
                        : result_i;

    // A response is only meaningful for a valid memory op; a stray strobe in
    // IDLE without a valid instruction changes nothing.
    rdata_hold_d = rdata_hold_q;
    if (data_data_ok && valid_i && mem_op && (state_q != S_HELD))
      rdata_hold_d = data_rdata;

    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i && mem_op) begin
          if (!data_data_ok)
            state_d = S_WAIT;
          else if (!ready_i)
            state_d = S_HELD;  // response in entry cycle but writeback stalled: keep it
        end
      end
      S_WAIT: begin
        if (data_data_ok)
          state_d = ready_i ? S_IDLE : S_HELD;
      end
      S_HELD: begin
        if (ready_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done_o   = done;
  assign fwd_addr = valid_i ? waddr_i : 5'd0;
  assign fwd_data = wdata;
  assign fwd_ok   = valid_i && done;

  // State, captured response and writeback payload; payload advances only when
  // writeback accepts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rdata_hold_q <= '0;
      valid_q      <= 1'b0;
      wen_q        <= 1'b0;
      pc_q         <= '0;
      inst_q       <= '0;
      wdata_q      <= '0;
      waddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      rdata_hold_q <= rdata_hold_d;
      if (ready_i) begin
        valid_q <= valid_i && done;
        pc_q    <= pc_i;
        inst_q  <= inst_i;
        waddr_q <= waddr_i;
        wdata_q <= wdata;
        wen_q   <= valid_i && done && (ctrl_i[`I_WEX] || ctrl_i[`I_MEM_R])
                   && (waddr_i != 5'd0);
      end
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign wen_o   = wen_q;

  logic unused_bits;
  assign unused_bits = ^{inst_i[25:0], eaddr_i[31:2], ctrl_i};

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: a table of instructions with hand-computed
// writeback values, driven with chosen response/ready timing, plus a sequence
// covering reset during an outstanding store and a stray response strobe.
`timescale 1ns/1ps
`ifndef I_MAX
`define I_MAX 8
`endif
`ifndef I_MEM_R
`define I_MEM_R 0
`endif
`ifndef I_MEM_W
`define I_MEM_W 1
`endif
`ifndef I_WEX
`define I_WEX 2
`endif

module tb_memory_stage;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_i;
  logic [31:0]       pc_i, inst_i, result_i, eaddr_i, rdata2_i;
  logic [`I_MAX-1:0] ctrl_i;
  logic [4:0]        waddr_i;
  logic              done_o;
  logic [31:0]       data_rdata;
  logic              data_data_ok;
  logic              ready_i;
  logic [4:0]        fwd_addr;
  logic [31:0]       fwd_data;
  logic              fwd_ok;
  logic              valid_o;
  logic [31:0]       pc_o, inst_o, wdata_o;
  logic [4:0]        waddr_o;
  logic              wen_o;

  memory_stage dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .ctrl_i(ctrl_i), .result_i(result_i), .eaddr_i(eaddr_i), .rdata2_i(rdata2_i),
    .waddr_i(waddr_i), .done_o(done_o), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok), .ready_i(ready_i), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_ok(fwd_ok), .valid_o(valid_o), .pc_o(pc_o),
    .inst_o(inst_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .wen_o(wen_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic [`I_MAX-1:0] ctrl;
    logic [31:0]       result;
    logic [31:0]       eaddr;
    logic [31:0]       rt;
    logic [31:0]       m;
    logic [4:0]        waddr;
    int                dok;   // cycles after entry when data_data_ok arrives
    int                hold;  // extra cycles ready_i stays low after the response
    logic [31:0]       exp_wdata;
    logic              exp_wen;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [`I_MAX-1:0] c_r, c_w, c_x, c_0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] pc, input logic [5:0] op,
                              input logic [`I_MAX-1:0] ctrl, input logic [31:0] result,
                              input logic [31:0] eaddr, input logic [31:0] rt,
                              input logic [31:0] m, input logic [4:0] waddr, input int dok,
                              input int hold, input logic [31:0] exp_wdata, input logic exp_wen);
    vec_t v;
    v.name = name; v.pc = pc; v.inst = {op, 26'h0ABCDE}; v.ctrl = ctrl;
    v.result = result; v.eaddr = eaddr; v.rt = rt; v.m = m; v.waddr = waddr;
    v.dok = dok; v.hold = hold; v.exp_wdata = exp_wdata; v.exp_wen = exp_wen;
    return v;
  endfunction

  task automatic idle_inputs();
    valid_i = 1'b0; pc_i = '0; inst_i = '0; ctrl_i = '0; result_i = '0;
    eaddr_i = '0; rdata2_i = '0; waddr_i = '0; data_rdata = 32'h5A5A5A5A;
    data_data_ok = 1'b0; ready_i = 1'b1;
  endtask

  // Drive one instruction, check per-cycle completion/forwarding, then pop the
  // scoreboard entry when the writeback register is loaded.
  task automatic run_vec(input vec_t v);
    bit   mem;
    int   fire;
    exp_t e;
    exp_t got;
    mem  = v.ctrl[`I_MEM_R] | v.ctrl[`I_MEM_W];
    fire = mem ? (v.dok + v.hold) : 0;
    e.name = v.name; e.pc = v.pc; e.inst = v.inst; e.waddr = v.waddr;
    e.wdata = v.exp_wdata; e.wen = v.exp_wen;
    @(negedge clk);
    valid_i = 1'b1; pc_i = v.pc; inst_i = v.inst; ctrl_i = v.ctrl; result_i = v.result;
    eaddr_i = v.eaddr; rdata2_i = v.rt; waddr_i = v.waddr;
    sb_q.push_back(e);
    for (int c = 0; c <= fire; c++) begin
      bit exp_done;
      data_data_ok = mem && (c == v.dok);
      data_rdata   = (mem && c == v.dok) ? v.m : (32'hDEADBEEF ^ 32'(c));
      ready_i      = (c >= fire);
      #1;
      exp_done = !mem || (c >= v.dok);
      check({v.name, ".done"}, 32'(done_o), 32'(exp_done));
      check({v.name, ".fwd_ok"}, 32'(fwd_ok), 32'(exp_done));
      check({v.name, ".fwd_addr"}, 32'(fwd_addr), 32'(v.waddr));
      check({v.name, ".valid_o_before"}, 32'(valid_o), 32'd0);
      if (exp_done) check({v.name, ".fwd_data"}, fwd_data, v.exp_wdata);
      @(posedge clk);
      if (c < fire) @(negedge clk);
    end
    #1;
    got = sb_q.pop_front();
    check({got.name, ".valid_o"}, 32'(valid_o), 32'd1);
    check({got.name, ".pc_o"}, pc_o, got.pc);
    check({got.name, ".inst_o"}, inst_o, got.inst);
    check({got.name, ".waddr_o"}, 32'(waddr_o), 32'(got.waddr));
    check({got.name, ".wdata_o"}, wdata_o, got.wdata);
    check({got.name, ".wen_o"}, 32'(wen_o), 32'(got.wen));
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    check({v.name, ".bubble_valid_o"}, 32'(valid_o), 32'd0);
    check({v.name, ".bubble_wen_o"}, 32'(wen_o), 32'd0);
  endtask

  initial begin
    c_0 = '0;
    c_r = '0; c_r[`I_MEM_R] = 1'b1; c_r[`I_WEX] = 1'b1;
    c_w = '0; c_w[`I_MEM_W] = 1'b1;
    c_x = '0; c_x[`I_WEX] = 1'b1;

    //        name      pc            op     ctrl result        eaddr         rt            m             wa  dok hold exp_wdata     wen
    tbl.push_back(mk("addu",    32'h00400000, 6'h00, c_x, 32'h00001234, 32'h0, 32'h0, 32'h0, 5'd5, 0, 0, 32'h00001234, 1'b1));
    tbl.push_back(mk("lb_off2", 32'h00400004, 6'h20, c_r, 32'h0, 32'h10000002, 32'h0, 32'h00800000, 5'd3, 2, 0, 32'hFFFFFF80, 1'b1));
    tbl.push_back(mk("lwl_off1",32'h00400008, 6'h22, c_r, 32'h0, 32'h10000001, 32'hAABBCCDD, 32'h11223344, 5'd8, 0, 0, 32'h3344CCDD, 1'b1));
    tbl.push_back(mk("lwr_off2",32'h0040000C, 6'h26, c_r, 32'h0, 32'h10000002, 32'hAABBCCDD, 32'h11223344, 5'd9, 1, 0, 32'hAABB1122, 1'b1));
    tbl.push_back(mk("lw_held", 32'h00400010, 6'h23, c_r, 32'h0, 32'h10000000, 32'h0, 32'hCAFEF00D, 5'd7, 1, 2, 32'hCAFEF00D, 1'b1));
    tbl.push_back(mk("sw",      32'h00400014, 6'h2B, c_w, 32'h00001000, 32'h10000000, 32'h0, 32'h77777777, 5'd0, 1, 0, 32'h00001000, 1'b0));
    tbl.push_back(mk("lw_r0",   32'h00400018, 6'h23, c_r, 32'h0, 32'h10000000, 32'h0, 32'h13579BDF, 5'd0, 2, 0, 32'h13579BDF, 1'b0));
    tbl.push_back(mk("lbu_off3",32'h0040001C, 6'h24, c_r, 32'h0, 32'h10000003, 32'h0, 32'h80FF7F01, 5'd10, 0, 0, 32'h00000080, 1'b1));
    tbl.push_back(mk("lh_off2", 32'h00400020, 6'h21, c_r, 32'h0, 32'h10000002, 32'h0, 32'h80017FFF, 5'd11, 1, 0, 32'hFFFF8001, 1'b1));
    tbl.push_back(mk("lhu_off0",32'h00400024, 6'h25, c_r, 32'h0, 32'h10000000, 32'h0, 32'h12348765, 5'd12, 0, 0, 32'h00008765, 1'b1));
    tbl.push_back(mk("lwl_off0",32'h00400028, 6'h22, c_r, 32'h0, 32'h10000000, 32'hAABBCCDD, 32'h11223344, 5'd13, 0, 0, 32'h44BBCCDD, 1'b1));
    tbl.push_back(mk("lwl_off3",32'h0040002C, 6'h22, c_r, 32'h0, 32'h10000003, 32'hAABBCCDD, 32'h11223344, 5'd14, 1, 1, 32'h11223344, 1'b1));
    tbl.push_back(mk("lwr_off1",32'h00400030, 6'h26, c_r, 32'h0, 32'h10000001, 32'hAABBCCDD, 32'h11223344, 5'd15, 0, 0, 32'hAA112233, 1'b1));
    tbl.push_back(mk("lwr_off3",32'h00400034, 6'h26, c_r, 32'h0, 32'h10000003, 32'hAABBCCDD, 32'h11223344, 5'd16, 2, 1, 32'hAABBCC11, 1'b1));
    tbl.push_back(mk("lb_off0", 32'h00400038, 6'h20, c_r, 32'h0, 32'h10000000, 32'h0, 32'h0000007F, 5'd17, 0, 0, 32'h0000007F, 1'b1));
    tbl.push_back(mk("addu_r0", 32'h0040003C, 6'h00, c_x, 32'h0000BEEF, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0000BEEF, 1'b0));
    tbl.push_back(mk("nowex",   32'h00400040, 6'h04, c_0, 32'h00000042, 32'h0, 32'h0, 32'h0, 5'd9, 0, 0, 32'h00000042, 1'b0));

    // Reset state
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid_o", 32'(valid_o), 32'd0);
    check("reset.wen_o", 32'(wen_o), 32'd0);
    check("reset.pc_o", pc_o, 32'd0);
    check("reset.wdata_o", wdata_o, 32'd0);
    check("reset.waddr_o", 32'(waddr_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset while a store is waiting for its response with writeback stalled.
    @(negedge clk);
    valid_i = 1'b1; pc_i = 32'h00500000; inst_i = 32'h00852821; ctrl_i = c_x;
    result_i = 32'h00000099; waddr_i = 5'd4; ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst.valid_o", 32'(valid_o), 32'd1);
    @(negedge clk);
    pc_i = 32'h00500004; inst_i = {6'h2B, 26'h0}; ctrl_i = c_w; waddr_i = 5'd0;
    ready_i = 1'b0; data_data_ok = 1'b0;
    #1;
    check("sw_wait.done", 32'(done_o), 32'd0);
    @(posedge clk);
    #1;
    check("sw_wait.valid_o_hold", 32'(valid_o), 32'd1);
    check("sw_wait.wdata_o_hold", wdata_o, 32'h00000099);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wait.valid_o", 32'(valid_o), 32'd0);
    check("rst_wait.wen_o", 32'(wen_o), 32'd0);
    check("rst_wait.pc_o", pc_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    data_data_ok = 1'b1; data_rdata = 32'hBADBAD00;
    #1;
    check("stray.done", 32'(done_o), 32'd0);
    check("stray.fwd_ok", 32'(fwd_ok), 32'd0);
    check("stray.fwd_addr", 32'(fwd_addr), 32'd0);
    @(posedge clk);
    #1;
    check("stray.valid_o", 32'(valid_o), 32'd0);
    @(negedge clk);
    data_data_ok = 1'b0;
    run_vec(mk("lw_after_rst", 32'h00500008, 6'h23, c_r, 32'h0, 32'h10000000, 32'h0,
               32'h0F1E2D3C, 5'd6, 2, 0, 32'h0F1E2D3C, 1'b1));

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
